// File: rtl/fight_pkg.sv
// Shared types for the match controller: player state codes, hit flag
// codes, match phases, winner codes, hitbox record and small helpers.
package fight_pkg;

  typedef enum logic [3:0] {
    P_IDLE              = 4'd0,
    P_MOVEFORWARDS      = 4'd1,
    P_MOVEBACKWARDS     = 4'd2,
    P_B_ATTACK_START    = 4'd3,
    P_B_ATTACK_END      = 4'd4,
    P_B_ATTACK_RECOVERY = 4'd5,
    P_D_ATTACK_START    = 4'd6,
    P_D_ATTACK_END      = 4'd7,
    P_D_ATTACK_RECOVERY = 4'd8,
    P_HITSTUN           = 4'd9,
    P_BLOCKSTUN         = 4'd10
  } player_state_t;

  typedef enum logic [1:0] {
    notHit           = 2'b00,
    hitByBasic       = 2'b01,
    hitByDirectional = 2'b10
  } hitflag_t;

  typedef enum logic [1:0] {
    M_IDLE      = 2'd0,
    M_COUNTDOWN = 2'd1,
    M_FIGHT     = 2'd2,
    M_KO        = 2'd3
  } match_state_t;

  typedef enum logic [1:0] {
    W_NONE  = 2'b00,
    W_LEFT  = 2'b01,
    W_RIGHT = 2'b10,
    W_DRAW  = 2'b11
  } winner_t;

  typedef struct packed {
    logic [9:0] x1;
    logic [9:0] x2;
    logic [9:0] y1;
    logic [9:0] y2;
  } box_t;

  // Inclusive rectangle overlap; touching edges count as contact.
  function automatic logic boxOverlap(input box_t a, input box_t b);
    return (a.x1 <= b.x2) && (b.x1 <= a.x2) && (a.y1 <= b.y2) && (b.y1 <= a.y2);
  endfunction

  // A swing is in progress only while an attack box can be live.
  function automatic logic isSwing(input logic [3:0] state);
    return (state == P_B_ATTACK_END) || (state == P_D_ATTACK_END);
  endfunction

  // Unblocked damage: basic costs 1, directional costs 2, floor at 0.
  function automatic logic [2:0] healthAfterHit(input logic [2:0] h, input hitflag_t kind);
    logic [2:0] dmg;
    dmg = (kind == hitByDirectional) ? 3'd2 : 3'd1;
    return (h > dmg) ? (h - dmg) : 3'd0;
  endfunction

endpackage

// File: rtl/fight_ctrl_if.sv
// Bundle of player-facing signals around the match controller. The master
// side is the top level / players, the slave side is fight_ctrl.
interface fight_ctrl_if;
  logic       start;
  logic [3:0] l_state;
  logic [3:0] r_state;
  logic [9:0] l_bas_x1, l_bas_x2, l_bas_y1, l_bas_y2;
  logic [9:0] l_dir_x1, l_dir_x2, l_dir_y1, l_dir_y2;
  logic [9:0] l_hurt_x1, l_hurt_x2, l_hurt_y1, l_hurt_y2;
  logic [9:0] r_bas_x1, r_bas_x2, r_bas_y1, r_bas_y2;
  logic [9:0] r_dir_x1, r_dir_x2, r_dir_y1, r_dir_y2;
  logic [9:0] r_hurt_x1, r_hurt_x2, r_hurt_y1, r_hurt_y2;
  logic [1:0] l_hitflag;
  logic [1:0] r_hitflag;
  logic [2:0] l_health;
  logic [2:0] r_health;
  logic [2:0] l_block;
  logic [2:0] r_block;
  logic       freeze;
  logic [1:0] match_state;
  logic [1:0] winner;

  modport master (
    output start, l_state, r_state,
    output l_bas_x1, l_bas_x2, l_bas_y1, l_bas_y2,
    output l_dir_x1, l_dir_x2, l_dir_y1, l_dir_y2,
    output l_hurt_x1, l_hurt_x2, l_hurt_y1, l_hurt_y2,
    output r_bas_x1, r_bas_x2, r_bas_y1, r_bas_y2,
    output r_dir_x1, r_dir_x2, r_dir_y1, r_dir_y2,
    output r_hurt_x1, r_hurt_x2, r_hurt_y1, r_hurt_y2,
    input  l_hitflag, r_hitflag, l_health, r_health,
    input  l_block, r_block, freeze, match_state, winner
  );

  modport slave (
    input  start, l_state, r_state,
    input  l_bas_x1, l_bas_x2, l_bas_y1, l_bas_y2,
    input  l_dir_x1, l_dir_x2, l_dir_y1, l_dir_y2,
    input  l_hurt_x1, l_hurt_x2, l_hurt_y1, l_hurt_y2,
    input  r_bas_x1, r_bas_x2, r_bas_y1, r_bas_y2,
    input  r_dir_x1, r_dir_x2, r_dir_y1, r_dir_y2,
    input  r_hurt_x1, r_hurt_x2, r_hurt_y1, r_hurt_y2,
    output l_hitflag, r_hitflag, l_health, r_health,
    output l_block, r_block, freeze, match_state, winner
  );
endinterface

// File: rtl/fight_ctrl_hit_detect.sv
// One attacker's hit test: pick the box that is live in the attacker's
// current state and test it against the defender's hurtbox.
module hit_detect
  import fight_pkg::*;
(
  input  logic [3:0] i_atkState,
  input  box_t       i_basBox,
  input  box_t       i_dirBox,
  input  box_t       i_hurtBox,
  output hitflag_t   o_hit
);

  // Active-box selection followed by the overlap test.
  always_comb begin
    o_hit = notHit;
    if ((i_atkState == P_B_ATTACK_END) && boxOverlap(i_basBox, i_hurtBox)) begin
      o_hit = hitByBasic;
    end else if ((i_atkState == P_D_ATTACK_END) && boxOverlap(i_dirBox, i_hurtBox)) begin
      o_hit = hitByDirectional;
    end
  end

endmodule

// File: rtl/fight_ctrl.sv
// Match controller: round FSM, per-frame hit resolution between the two
// players, health/block bookkeeping and input freeze.
module fight_ctrl
  import fight_pkg::*;
#(
  parameter int HEALTH_INIT  = 5,
  parameter int BLOCK_INIT   = 3,
  parameter int BLOCK_REGEN  = 60,
  parameter int COUNTDOWN    = 120,
  parameter int ROUND_FRAMES = 3600,
  parameter int KO_HOLD      = 180
) (
  input  logic clk,
  input  logic rst_n,
  fight_ctrl_if.slave bus
);

  // One phase counter serves countdown, fight and KO; size it for the longest.
  localparam int CNT_SPAN = (ROUND_FRAMES > COUNTDOWN)
                          ? ((ROUND_FRAMES > KO_HOLD) ? ROUND_FRAMES : KO_HOLD)
                          : ((COUNTDOWN > KO_HOLD) ? COUNTDOWN : KO_HOLD);
  localparam int CNT_W   = $clog2(CNT_SPAN);
  localparam int REGEN_W = $clog2(BLOCK_REGEN);

  localparam logic [CNT_W-1:0]   C_CD_LAST    = CNT_W'(COUNTDOWN - 1);
  localparam logic [CNT_W-1:0]   C_ROUND_LAST = CNT_W'(ROUND_FRAMES - 1);
  localparam logic [CNT_W-1:0]   C_KO_LAST    = CNT_W'(KO_HOLD - 1);
  localparam logic [REGEN_W-1:0] C_REGEN_LAST = REGEN_W'(BLOCK_REGEN - 1);
  localparam logic [2:0]         C_HEALTH     = 3'(HEALTH_INIT);
  localparam logic [2:0]         C_BLOCK      = 3'(BLOCK_INIT);

  match_state_t        r_state, w_nextState;
  winner_t             r_winner, w_nextWinner;
  logic [CNT_W-1:0]    r_frameCnt;
  logic [2:0]          r_lHealth, r_rHealth, w_lHealthNxt, w_rHealthNxt;
  logic [2:0]          r_lBlock, r_rBlock, w_lBlockNxt, w_rBlockNxt;
  logic [REGEN_W-1:0]  r_lRegen, r_rRegen, w_lRegenNxt, w_rRegenNxt;
  logic                r_lConn, r_rConn;
  hitflag_t            r_lHitflag, r_rHitflag;
  hitflag_t            w_lAtkRaw, w_rAtkRaw, w_lAtkHit, w_rAtkHit;
  logic                w_roundLoad, w_detectEn;
  box_t                w_lBas, w_lDir, w_lHurt, w_rBas, w_rDir, w_rHurt;

  assign w_lBas  = {bus.l_bas_x1,  bus.l_bas_x2,  bus.l_bas_y1,  bus.l_bas_y2};
  assign w_lDir  = {bus.l_dir_x1,  bus.l_dir_x2,  bus.l_dir_y1,  bus.l_dir_y2};
  assign w_lHurt = {bus.l_hurt_x1, bus.l_hurt_x2, bus.l_hurt_y1, bus.l_hurt_y2};
  assign w_rBas  = {bus.r_bas_x1,  bus.r_bas_x2,  bus.r_bas_y1,  bus.r_bas_y2};
  assign w_rDir  = {bus.r_dir_x1,  bus.r_dir_x2,  bus.r_dir_y1,  bus.r_dir_y2};
  assign w_rHurt = {bus.r_hurt_x1, bus.r_hurt_x2, bus.r_hurt_y1, bus.r_hurt_y2};

  hit_detect u_leftAtk (
    .i_atkState (bus.l_state),
    .i_basBox   (w_lBas),
    .i_dirBox   (w_lDir),
    .i_hurtBox  (w_rHurt),
    .o_hit      (w_lAtkRaw)
  );

  hit_detect u_rightAtk (
    .i_atkState (bus.r_state),
    .i_basBox   (w_rBas),
    .i_dirBox   (w_rDir),
    .i_hurtBox  (w_lHurt),
    .o_hit      (w_rAtkRaw)
  );

  // Detection is suppressed in the cycle that decides KO or timeout, so no
  // flag ever lands while the match is leaving the fight phase.
  assign w_roundLoad = (r_state == M_IDLE) && bus.start;
  assign w_detectEn  = (r_state == M_FIGHT) && (r_lHealth != 3'd0) &&
                       (r_rHealth != 3'd0) && (r_frameCnt != C_ROUND_LAST);
  assign w_lAtkHit   = (w_detectEn && !r_lConn) ? w_lAtkRaw : notHit;
  assign w_rAtkHit   = (w_detectEn && !r_rConn) ? w_rAtkRaw : notHit;

  // Match FSM next state and winner decision; KO outranks timeout.
  always_comb begin
    w_nextState  = r_state;
    w_nextWinner = r_winner;
    case (r_state)
      M_IDLE: begin
        if (bus.start) begin
          w_nextState  = M_COUNTDOWN;
          w_nextWinner = W_NONE;
        end
      end
      M_COUNTDOWN: begin
        if (r_frameCnt == C_CD_LAST) w_nextState = M_FIGHT;
      end
      M_FIGHT: begin
        if ((r_lHealth == 3'd0) || (r_rHealth == 3'd0)) begin
          w_nextState = M_KO;
          if ((r_lHealth == 3'd0) && (r_rHealth == 3'd0)) w_nextWinner = W_DRAW;
          else if (r_lHealth == 3'd0)                     w_nextWinner = W_RIGHT;
          else                                            w_nextWinner = W_LEFT;
        end else if (r_frameCnt == C_ROUND_LAST) begin
          w_nextState = M_KO;
          if (r_lHealth > r_rHealth)      w_nextWinner = W_LEFT;
          else if (r_lHealth < r_rHealth) w_nextWinner = W_RIGHT;
          else                            w_nextWinner = W_DRAW;
        end
      end
      M_KO: begin
        if (r_frameCnt == C_KO_LAST) w_nextState = M_IDLE;
      end
      default: w_nextState = M_IDLE;
    endcase
  end

  // Match state, winner and phase counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= M_IDLE;
      r_winner   <= W_NONE;
      r_frameCnt <= '0;
    end else begin
      r_state  <= w_nextState;
      r_winner <= w_nextWinner;
      if ((w_nextState != r_state) || (r_state == M_IDLE)) r_frameCnt <= '0;
      else                                                 r_frameCnt <= r_frameCnt + CNT_W'(1);
    end
  end

  // Right defender: regen in fight, then a hit by the left player overrides.
  always_comb begin
    w_rHealthNxt = r_rHealth;
    w_rBlockNxt  = r_rBlock;
    w_rRegenNxt  = r_rRegen;
    if (r_state == M_FIGHT) begin
      if (r_rBlock >= C_BLOCK) begin
        w_rRegenNxt = '0;
      end else if (r_rRegen == C_REGEN_LAST) begin
        w_rBlockNxt = r_rBlock + 3'd1;
        w_rRegenNxt = '0;
      end else begin
        w_rRegenNxt = r_rRegen + REGEN_W'(1);
      end
    end
    if (w_lAtkHit != notHit) begin
      if ((bus.r_state == P_MOVEBACKWARDS) && (r_rBlock != 3'd0)) begin
        w_rBlockNxt = r_rBlock - 3'd1;
        w_rRegenNxt = '0;
      end else begin
        w_rHealthNxt = healthAfterHit(r_rHealth, w_lAtkHit);
      end
    end
  end

  // Left defender: mirror of the right side.
  always_comb begin
    w_lHealthNxt = r_lHealth;
    w_lBlockNxt  = r_lBlock;
    w_lRegenNxt  = r_lRegen;
    if (r_state == M_FIGHT) begin
      if (r_lBlock >= C_BLOCK) begin
        w_lRegenNxt = '0;
      end else if (r_lRegen == C_REGEN_LAST) begin
        w_lBlockNxt = r_lBlock + 3'd1;
        w_lRegenNxt = '0;
      end else begin
        w_lRegenNxt = r_lRegen + REGEN_W'(1);
      end
    end
    if (w_rAtkHit != notHit) begin
      if ((bus.l_state == P_MOVEBACKWARDS) && (r_lBlock != 3'd0)) begin
        w_lBlockNxt = r_lBlock - 3'd1;
        w_lRegenNxt = '0;
      end else begin
        w_lHealthNxt = healthAfterHit(r_lHealth, w_rAtkHit);
      end
    end
  end

  // Health, block, regen, one-hit-per-swing and registered hit flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lHealth  <= C_HEALTH;
      r_rHealth  <= C_HEALTH;
      r_lBlock   <= C_BLOCK;
      r_rBlock   <= C_BLOCK;
      r_lRegen   <= '0;
      r_rRegen   <= '0;
      r_lConn    <= 1'b0;
      r_rConn    <= 1'b0;
      r_lHitflag <= notHit;
      r_rHitflag <= notHit;
    end else begin
      r_lHitflag <= w_rAtkHit;
      r_rHitflag <= w_lAtkHit;
      if (w_roundLoad) begin
        r_lHealth <= C_HEALTH;
        r_rHealth <= C_HEALTH;
        r_lBlock  <= C_BLOCK;
        r_rBlock  <= C_BLOCK;
        r_lRegen  <= '0;
        r_rRegen  <= '0;
        r_lConn   <= 1'b0;
        r_rConn   <= 1'b0;
      end else begin
        r_lHealth <= w_lHealthNxt;
        r_rHealth <= w_rHealthNxt;
        r_lBlock  <= w_lBlockNxt;
        r_rBlock  <= w_rBlockNxt;
        r_lRegen  <= w_lRegenNxt;
        r_rRegen  <= w_rRegenNxt;
        if (!isSwing(bus.l_state))     r_lConn <= 1'b0;
        else if (w_lAtkHit != notHit)  r_lConn <= 1'b1;
        if (!isSwing(bus.r_state))     r_rConn <= 1'b0;
        else if (w_rAtkHit != notHit)  r_rConn <= 1'b1;
      end
    end
  end

  assign bus.l_hitflag   = r_lHitflag;
  assign bus.r_hitflag   = r_rHitflag;
  assign bus.l_health    = r_lHealth;
  assign bus.r_health    = r_rHealth;
  assign bus.l_block     = r_lBlock;
  assign bus.r_block     = r_rBlock;
  assign bus.match_state = r_state;
  assign bus.winner      = r_winner;
  assign bus.freeze      = (r_state != M_FIGHT);

endmodule

// File: doc/fight_ctrl.md
# fight_ctrl

Match controller for the two-player fighter. It sits between the two `player` instances and the top level, and owns the round sequence (countdown, fight, KO or timeout). Every frame it checks each player's active hitbox against the opponent's main hurtbox, drives each player's `hitFlag`, and maintains the `health` and `block` values those players consume. It also freezes player inputs outside the fight phase.

## Interface
- `HEALTH_INIT`, 5: health loaded at round start (3-bit, max 7).
- `BLOCK_INIT`, 3: block charges loaded at round start; also the regen ceiling.
- `BLOCK_REGEN`, 60: frames without a blocked hit before one charge is restored.
- `COUNTDOWN`, 120: frames in `M_COUNTDOWN`.
- `ROUND_FRAMES`, 3600: fight-phase frame limit.
- `KO_HOLD`, 180: frames in `M_KO` before returning to `M_IDLE`.
- `clk` input 1: frame-tick clock, the same clock that drives the players.
- `rst_n` input 1: reset; one clock; reset is asynchronous and active-low.
- `start` input 1: level; sampled only in `M_IDLE`.
- `l_state`, `r_state` input 4 each: each player's `current_state`.
- `l_bas_x1/x2/y1/y2`, `l_dir_x1/x2/y1/y2`, `l_hurt_x1/x2/y1/y2` input 10 each: left player's boxes. Right player has identical `r_*` ports.
- `l_hitflag`, `r_hitflag` output 2 each: `hitFlag` to each player (00 none, 01 basic, 10 directional).
- `l_health`, `r_health` output 3 each: current health.
- `l_block`, `r_block` output 3 each: current block charges.
- `freeze` output 1: high outside `M_FIGHT`; the top level gates `left/right/attack` with it.
- `match_state` output 2: 0 `M_IDLE`, 1 `M_COUNTDOWN`, 2 `M_FIGHT`, 3 `M_KO`.
- `winner` output 2: 00 none, 01 left, 10 right, 11 draw.

## Operation
- **Active hitbox.**
  - Attacker in state 4 (B_ATTACK_END): the basic box is active.
  - Attacker in state 7 (D_ATTACK_END): the directional box is active.
  - Any other state: no box is active.
- **Overlap test.** Inclusive rectangle overlap between the active box and the opponent's hurtbox: `a.x1<=b.x2 && b.x1<=a.x2 && a.y1<=b.y2 && b.y1<=a.y2`. All coordinates are 10-bit unsigned.
- **One hit per swing.** Each attacker has a `connected` bit.
  - Set on a detected hit.
  - Cleared in any cycle the attacker is in neither state 4 nor 7.
  - While `connected` is set, no further hit is detected for that attacker.
- **Blocked hit.** The defender is in state 2 (MOVEBACKWARDS) and block > 0.
  - Block decrements by 1.
  - Health is unchanged.
  - The defender's regen timer resets.
  - The flag is still driven (basic or directional), so the player enters blockstun.
- **Unblocked hit.** Health decreases by 1 for a basic hit or 2 for a directional hit, saturating at 0.
- **Trades.** Both players hitting in the same cycle is legal. Both flags are driven and both health updates apply on the same edge.
- **Block regen.**
  - Per-player frame counter, active in `M_FIGHT` only.
  - When it reaches `BLOCK_REGEN-1` and block < `BLOCK_INIT`: block +1 and the counter clears.
  - When block equals `BLOCK_INIT`, the counter is held at 0.
- **Match FSM.**
  - `M_IDLE` → `M_COUNTDOWN` on `start`. Entering `M_COUNTDOWN` reloads health and block, clears `winner`, `connected`, and the regen and round counters.
  - `M_COUNTDOWN` → `M_FIGHT` after `COUNTDOWN` frames.
  - `M_FIGHT` → `M_KO` when any health becomes 0:
    - both at 0: draw;
    - one at 0: the other player wins.
  - `M_FIGHT` → `M_KO` when the round counter reaches `ROUND_FRAMES-1`: higher health wins, equal health is a draw. Reaching 0 health in that same cycle takes priority via the KO rule.
  - `M_KO` → `M_IDLE` after `KO_HOLD` frames. `winner` holds its value until the next `M_COUNTDOWN`.
- **Flag gating.** Hit detection runs only in `M_FIGHT`. Flags are 00 in every other state.

## Timing
- **Reset values.**
  - `match_state` = `M_IDLE`, `freeze` = 1, flags = 00, `winner` = 00.
  - Health = `HEALTH_INIT`, block = `BLOCK_INIT`.
  - All counters and `connected` bits = 0.
- **Reset behaviour.** Reset is asynchronous and may assert mid-round. It returns everything to the reset values above immediately.
- **Hit latency.** Detection is combinational on registered inputs at cycle N. The flag is registered and visible at N+1 for exactly one cycle, and the health/block update is visible at N+1. A player therefore transitions at N+2.
- **KO latency.** KO uses the registered health. `match_state` becomes `M_KO` one cycle after the health-0 cycle, and no flags are issued in that intervening cycle.
- **`freeze`** is combinational from `match_state`.

## Structure
- **Package `fight_pkg`:**
  - player state codes (0–10);
  - `hitFlag` codes (`notHit`, `hitByBasic`, `hitByDirectional`);
  - match state codes;
  - winner codes.
- **Sub-module `hit_detect`**, instantiated twice, once per attacker direction.
  - Inputs: attacker state, both attacker boxes, defender hurtbox.
  - Output: 2-bit hit kind (active-box selection plus overlap test).
- **Kept in `fight_ctrl`:** the match FSM, counters, and health/block registers.

## Test plan
- **Basic hit:** `start`, wait 120 frames. Left in state 4 with boxes overlapping, right idle → `r_hitflag`=01 for one cycle, `r_health` 5→4. Holding state 4 for 2 more frames produces no second hit.
- **Blocked directional hit:** right in state 2 with block=3, left in state 7 overlapping → `r_hitflag`=10, `r_block`=2, `r_health`=5. After 60 clean frames, `r_block`=3.
- **Trade:** both in state 7, mutually overlapping → both flags 10 on the same cycle, both health 5→3.
- **KO:** right at health 1 takes a directional hit → health 0, next cycle `match_state`=3, `winner`=01, `freeze`=1. After 180 frames, `match_state`=0.
- **Timeout:** no hits, `l_health`=5, `r_health`=4 at frame 3599 → `winner`=01. With equal health → `winner`=11.
- **Reset mid-fight:** drop `rst_n` with health 2/3 → immediately `M_IDLE`, health 5/5, block 3/3, flags 00.
